// File: rtl/mc_control.sv
// Multicycle MIPS-style control unit: Moore FSM decoding datapath controls from the state.
// Optional macro BALRZ_EN adds the BALRZ (R-type funct 010110) branch-and-link-on-zero path.
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] memtoreg,
    output logic [1:0] regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       aluop1,
    output logic       aluop0,
    output logic [1:0] pcsource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
`ifdef BALRZ_EN
        ,
        BALRZ  = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

`ifdef BALRZ_EN
    localparam logic [5:0] FUNCT_BALRZ = 6'b010110;
`else
    logic unused_funct;
    assign unused_funct = ^funct;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every output and next_state gets a default first so no latch is inferred.
    always_comb begin
        state_d     = FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 2'b00;
        regdst      = 2'b00;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;

        // Reset masks every output so an aborted instruction cannot strobe a write.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    memread = 1'b1;
                    irwrite = 1'b1;
                    alusrcb = 2'b01;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_R:         state_d = EXEC;
                        OP_BEQ:       state_d = BEQ;
                        OP_J:         state_d = JUMP;
                        OP_ADDI:      state_d = ADDIEX;
                        default: begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = (op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                    state_d = MEMWB;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 2'b01;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
`ifdef BALRZ_EN
                    state_d = (funct == FUNCT_BALRZ) ? BALRZ : RWB;
`else
                    state_d = RWB;
`endif
                end
                RWB: begin
                    regwrite = 1'b1;
                    regdst   = 2'b01;
                end
                BEQ: begin
                    alusrca     = 1'b1;
                    aluop       = 2'b01;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = ADDIWB;
                end
                ADDIWB: begin
                    regwrite = 1'b1;
                end
`ifdef BALRZ_EN
                BALRZ: begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                    pcsource = 2'b11;
                    pcwrite  = zero;
                end
`endif
                default: state_d = FETCH;
            endcase
        end
    end

    assign state  = state_q;
    assign aluop1 = aluop[1];
    assign aluop0 = aluop[0];

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle model comparison plus literal spot checks.
// Build with +define+BALRZ_EN to exercise the BALRZ path.
module tb_mc_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] memtoreg;
        logic [1:0] regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic [1:0] memtoreg, regdst, alusrcb, pcsource;
    logic       regwrite, alusrca, aluop1, aluop0, illegal;
    logic [3:0] state;

    int   n_checks = 0;
    int   n_errors = 0;
    ctl_t exp_q[$];
    ctl_t seen[8];
    logic [31:0] seq;

    mc_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1), .aluop0(aluop0),
        .pcsource(pcsource), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t c;
        c = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
             memtoreg, regdst, regwrite, alusrca, alusrcb, {aluop1, aluop0},
             pcsource, illegal};
        return c;
    endfunction

    // Control word a state must present, read straight from the state descriptions.
    function automatic ctl_t ctl_for(input int st, input logic z, input logic ill);
        ctl_t c;
        c = '0;
        c.state = 4'(st);
        case (st)
            0:  begin c.memread = 1; c.irwrite = 1; c.alusrcb = 2'b01; c.pcwrite = 1; end
            1:  begin c.alusrcb = 2'b11; c.illegal = ill; end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  begin c.memread = 1; c.iord = 1; end
            4:  begin c.regwrite = 1; c.memtoreg = 2'b01; end
            5:  begin c.memwrite = 1; c.iord = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regwrite = 1; c.regdst = 2'b01; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcwritecond = 1; c.pcsource = 2'b01; end
            9:  begin c.pcwrite = 1; c.pcsource = 2'b10; end
            10: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            11: begin c.regwrite = 1; end
            12: begin c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10;
                      c.pcsource = 2'b11; c.pcwrite = z; end
            default: ;
        endcase
        return c;
    endfunction

    // Instruction-level model: the state path an opcode walks, starting at FETCH.
    task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              output int len);
        int  path[$];
        logic ill = 1'b0;
        case (o)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            6'b000000: begin
`ifdef BALRZ_EN
                if (f == 6'b010110) path = '{0, 1, 6, 12};
                else                path = '{0, 1, 6, 7};
`else
                path = '{0, 1, 6, 7};
`endif
            end
            default: begin path = '{0, 1}; ill = 1'b1; end
        endcase
        foreach (path[i]) exp_q.push_back(ctl_for(path[i], z, ill));
        len = path.size();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t e;
            ctl_t g;
            e = exp_q.pop_front();
            g = observed();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL cycle_compare t=%0t: got %h expected %h (exp state %0d)",
                         $time, g, e, e.state);
            end
        end
    end

    // Runs one instruction from FETCH, recording its state sequence and control words.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             output int len);
        op = o; funct = f; zero = z;
        push_instr(o, f, z, len);
        seq = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk); #1;
            seen[i] = observed();
            seq = (seq << 4) | 32'(state);
        end
        @(posedge clk); #1;
    endtask

    function automatic int count_memwrite(input int len);
        int n = 0;
        for (int i = 0; i < len; i++) n += int'(seen[i].memwrite);
        return n;
    endfunction

    function automatic int count_regwrite(input int len);
        int n = 0;
        for (int i = 0; i < len; i++) n += int'(seen[i].regwrite);
        return n;
    endfunction

    initial begin
        int len;
        reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("reset_outputs_zero", 32'(observed()), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'b100011, 6'd0, 1'b0, len);
        check("lw_seq", seq, 32'h01234);
        check("lw_fetch_memread", 32'(seen[0].memread), 32'd1);
        check("lw_memrd_memread", 32'(seen[3].memread), 32'd1);
        check("lw_regwrite_count", 32'(count_regwrite(len)), 32'd1);
        check("lw_memwb_memtoreg", {30'd0, seen[4].memtoreg}, 32'd1);

        run_instr(6'b101011, 6'd0, 1'b1, len);
        check("sw_seq", seq, 32'h0125);
        check("sw_memwrite_count", 32'(count_memwrite(len)), 32'd1);
        check("sw_memwr_iord", 32'(seen[3].iord), 32'd1);
        check("sw_regwrite_count", 32'(count_regwrite(len)), 32'd0);

        run_instr(6'b000100, 6'd0, 1'b1, len);
        check("beq_seq", seq, 32'h018);
        check("beq_aluop", {30'd0, seen[2].aluop}, 32'd1);
        check("beq_pcwritecond", 32'(seen[2].pcwritecond), 32'd1);

        run_instr(6'b000010, 6'd0, 1'b0, len);
        check("j_seq", seq, 32'h019);
        check("j_pcsource", {30'd0, seen[2].pcsource}, 32'd2);

        run_instr(6'b111111, 6'd0, 1'b0, len);
        check("illegal_seq", seq, 32'h01);
        check("illegal_pulse", 32'(seen[1].illegal), 32'd1);
        check("illegal_no_writes",
              32'(count_memwrite(len) + count_regwrite(len) + int'(seen[1].pcwritecond)), 32'd0);

        run_instr(6'b001000, 6'd0, 1'b0, len);
        check("addi_seq", seq, 32'h01AB);

        run_instr(6'b000000, 6'b100000, 1'b0, len);
        check("r_seq", seq, 32'h0167);

`ifdef BALRZ_EN
        run_instr(6'b000000, 6'b010110, 1'b1, len);
        check("balrz_seq", seq, 32'h016C);
        check("balrz_regdst", {30'd0, seen[3].regdst}, 32'd2);
        check("balrz_pcwrite_z1", 32'(seen[3].pcwrite), 32'd1);
        run_instr(6'b000000, 6'b010110, 1'b0, len);
        check("balrz_pcwrite_z0", 32'(seen[3].pcwrite), 32'd0);
`else
        run_instr(6'b000000, 6'b010110, 1'b1, len);
        check("balrz_disabled_seq", seq, 32'h0167);
`endif

        // Abort a load in MEMRD with an asynchronous reset pulse.
        op = 6'b100011; funct = '0; zero = 1'b0;
        push_instr(6'b100011, 6'd0, 1'b0, len);
        void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
        end
        check("abort_in_memrd", 32'(state), 32'd3);
        reset = 1'b1; #1;
        check("abort_outputs_zero", 32'(observed()), 32'h0);
        @(posedge clk); #1;
        check("abort_held_zero", 32'(observed()), 32'h0);
        reset = 1'b0;

        run_instr(6'b100011, 6'd0, 1'b0, len);
        check("post_reset_fetch_state", 32'(seen[0].state), 32'd0);
        check("post_reset_fetch_pcwrite", 32'(seen[0].pcwrite), 32'd1);
        check("post_reset_fetch_irwrite", 32'(seen[0].irwrite), 32'd1);
        check("post_reset_lw_seq", seq, 32'h01234);

        check("model_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 op  in  6  instruction opcode from IR.
REQ-004 funct  in  6  instruction function field from IR.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 pcwrite  out  1  unconditional PC write enable.
REQ-007 pcwritecond  out  1  PC write enable qualified by zero in the datapath.
REQ-008 iord  out  1  memory address select: 0 is PC, 1 is ALUOut.
REQ-009 memread  out  1  memory read strobe.
REQ-010 memwrite  out  1  memory write strobe.
REQ-011 irwrite  out  1  IR load enable.
REQ-012 memtoreg  out  2  register write-data select: 00 ALUOut, 01 MDR, 10 PC.
REQ-013 regdst  out  2  destination select: 00 rt, 01 rd, 10 $31.
REQ-014 regwrite  out  1  register file write enable.
REQ-015 alusrca  out  1  ALU A select: 0 PC, 1 rs.
REQ-016 alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-017 aluop1, aluop0  out  1 each  drive the ALU control unit: 00 add, 01 subtract, 10 use funct.
REQ-018 pcsource  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
REQ-019 state  out  4  current state code for debug.
REQ-020 illegal  out  1  one-cycle pulse in DECODE when op is unsupported.

Function
REQ-021 Moore FSM with a 4-bit state register; all outputs decode combinationally from the state only, except illegal and the BALRZ pcwrite.
REQ-022 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, JUMP 9, ADDIEX 10, ADDIWB 11, BALRZ 12.
REQ-023 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-024 FETCH: memread=1, irwrite=1, alusrcb=01, aluop=00, pcsource=00, pcwrite=1; next state DECODE.
REQ-025 DECODE: alusrcb=11, aluop=00. Next state is MEMADR for lw/sw, EXEC for R, BEQ for beq, JUMP for j, ADDIEX for addi; any other op gives FETCH with illegal=1.
REQ-026 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD for lw, MEMWR for sw.
REQ-027 MEMRD: memread=1, iord=1; next state MEMWB. MEMWB: regwrite=1, memtoreg=01, regdst=00; next state FETCH.
REQ-028 MEMWR: memwrite=1, iord=1; next state FETCH.
REQ-029 EXEC: alusrca=1, alusrcb=00, aluop=10; next state RWB, or BALRZ per REQ-036. RWB: regwrite=1, regdst=01, memtoreg=00; next state FETCH.
REQ-030 BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; next state FETCH.
REQ-031 JUMP: pcwrite=1, pcsource=10; next state FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB. ADDIWB: regwrite=1, regdst=00, memtoreg=00; next state FETCH.
REQ-033 Every output not listed for a state is 0; unused state codes 13-15 return to FETCH with all outputs 0.
REQ-034 Latencies in cycles, FETCH included: lw 5, sw 4, R 4, addi 4, beq 3, j 3, balrz 4.

Reset
REQ-035 While reset is high, state=FETCH (0) and every output is forced to 0; the first FETCH outputs appear in the cycle after reset falls. Reset asserted mid-instruction aborts it immediately with no further write strobes.

Configuration
REQ-036 Macro BALRZ_EN. When defined, R-type with funct 010110 goes EXEC -> BALRZ. BALRZ: regwrite=1, regdst=10, memtoreg=10, pcsource=11, pcwrite=zero; next state FETCH. When undefined, the BALRZ state is absent, funct is ignored, and every R-type takes the RWB path.

Verification
REQ-037 reset pulse mid-MEMRD -> all outputs 0 during reset; state=0 and FETCH outputs on the first clock after release.
REQ-038 op=100011 -> state sequence 0,1,2,3,4,0; memread=1 in states 0 and 3; regwrite=1 only in state 4 with memtoreg=01.
REQ-039 op=101011 -> sequence 0,1,2,5,0; memwrite=1 for exactly one cycle with iord=1; regwrite never set.
REQ-040 op=000100 -> sequence 0,1,8,0; state 8 drives aluop1=0, aluop0=1, pcwritecond=1. op=000010 -> sequence 0,1,9,0 with pcsource=10.
REQ-041 op=111111 -> illegal=1 for one cycle in state 1, then state=0; no write strobes are asserted.
REQ-042 With BALRZ_EN, op=000000 and funct=010110 -> sequence 0,1,6,12,0; state 12 gives regdst=10, pcwrite=1 when zero=1 and pcwrite=0 when zero=0. Without BALRZ_EN the same stimulus gives sequence 0,1,6,7,0.
